// File: rtl/vfat_sbit_pkg.sv
// Shared encodings and helpers for the VFAT3 S-bit transmitter emulator.
// Mode encodings, frame geometry and a saturating counter step.
package vfat_sbit_pkg;

    typedef enum logic [1:0] {
        MODE_DATA    = 2'd0,
        MODE_FIXED   = 2'd1,
        MODE_COUNTER = 2'd2,
        MODE_IDLE    = 2'd3
    } mode_e;

    localparam int FRAME_BITS = 8;
    localparam int SKEW_W     = 3;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vfat_sbit_tx_if.sv
// Frame source handshake between a frame producer and the S-bit transmitter.
// The source holds frame_i while valid is high and ready is low.
interface vfat_sbit_tx_if #(
    parameter int NLANES = 8
);
    logic [NLANES*8-1:0] frame_i;
    logic                frame_valid_i;
    logic                frame_ready_o;

    modport master (
        output frame_i,
        output frame_valid_i,
        input  frame_ready_o
    );

    modport slave (
        input  frame_i,
        input  frame_valid_i,
        output frame_ready_o
    );
endinterface

// File: rtl/sbit_skew_sr.sv
// Single-bit delay line with a runtime tap; tap 0 is the first register stage.
// Shifts every clock so the line drains even when the transmitter is idle.
module sbit_skew_sr #(
    parameter int DEPTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             din,
    input  logic [SEL_W-1:0] tap,
    output logic             dout
);

    logic [DEPTH-1:0] sr;

    // Shift the raw bit in; reset only clears the line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign dout = sr[tap];

endmodule

// File: rtl/vfat_sbit_tx.sv
// VFAT3 S-bit transmitter emulator: 8-bit frames, LSB first, on NLANES lanes plus SOF.
// Each lane and SOF pass through a tapped delay line to emulate per-lane skew.
module vfat_sbit_tx
    import vfat_sbit_pkg::*;
#(
    parameter int NLANES   = 8,
    parameter int MAX_SKEW = 7
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_i,
    input  logic [1:0]               mode_i,
    input  logic [7:0]               pattern_i,
    vfat_sbit_tx_if.slave            src,
    input  logic [NLANES*SKEW_W-1:0] lane_skew_i,
    input  logic [SKEW_W-1:0]        sof_skew_i,
    output logic [NLANES-1:0]        sbits_o,
    output logic                     sof_o,
    output logic [15:0]              frame_cnt_o,
    output logic [15:0]              underflow_cnt_o
);

    logic [2:0]                   bit_cnt;
    logic                         active;
    logic                         boundary;
    logic                         is_data;
    logic [NLANES*FRAME_BITS-1:0] frame_reg;
    logic [NLANES*FRAME_BITS-1:0] frame_nxt;
    logic [NLANES-1:0]            raw;
    logic                         sof_raw;

    assign boundary = enable_i && (bit_cnt == 3'd7);
    assign is_data  = (mode_i == MODE_DATA);

    assign src.frame_ready_o = boundary && is_data;

    // Select the frame loaded at the next boundary from the current mode.
    always_comb begin
        frame_nxt = '0;
        unique case (mode_e'(mode_i))
            MODE_DATA: begin
                if (src.frame_valid_i) begin
                    frame_nxt = src.frame_i;
                end
            end
            MODE_FIXED:   frame_nxt = {NLANES{pattern_i}};
            MODE_COUNTER: frame_nxt = {NLANES{frame_cnt_o[7:0]}};
            MODE_IDLE:    frame_nxt = '0;
        endcase
    end

    // Bit counter, frame register and frame/underflow counters.
    // 'active' blocks stale bits of an abandoned frame after re-enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt         <= 3'd7;
            active          <= 1'b0;
            frame_reg       <= '0;
            frame_cnt_o     <= '0;
            underflow_cnt_o <= '0;
        end else if (!enable_i) begin
            bit_cnt <= 3'd7;
            active  <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (boundary) begin
                frame_reg   <= frame_nxt;
                active      <= 1'b1;
                frame_cnt_o <= frame_cnt_o + 16'd1;
                if (is_data && !src.frame_valid_i) begin
                    underflow_cnt_o <= sat_inc(underflow_cnt_o);
                end
            end
        end
    end

    assign sof_raw = active && enable_i && (bit_cnt == 3'd0);

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        logic [FRAME_BITS-1:0] lane_byte;

        assign lane_byte = frame_reg[i*FRAME_BITS +: FRAME_BITS];
        assign raw[i]    = active && enable_i && lane_byte[bit_cnt];

        sbit_skew_sr #(
            .DEPTH (MAX_SKEW + 1),
            .SEL_W (SKEW_W)
        ) u_sr (
            .clock (clock),
            .reset (reset),
            .din   (raw[i]),
            .tap   (lane_skew_i[i*SKEW_W +: SKEW_W]),
            .dout  (sbits_o[i])
        );
    end

    sbit_skew_sr #(
        .DEPTH (MAX_SKEW + 1),
        .SEL_W (SKEW_W)
    ) u_sof_sr (
        .clock (clock),
        .reset (reset),
        .din   (sof_raw),
        .tap   (sof_skew_i),
        .dout  (sof_o)
    );

endmodule

// File: tb/tb_vfat_sbit_tx.sv
// Self-checking bench for vfat_sbit_tx: table-driven DATA vectors
// plus stream sequences checked against a frame/skew timing model.
module tb_vfat_sbit_tx;
    import vfat_sbit_pkg::*;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  pattern;
    logic [23:0] lane_skew;
    logic [2:0]  sof_skew;
    logic [7:0]  sbits;
    logic        sof;
    logic [15:0] frame_cnt;
    logic [15:0] underflow_cnt;

    int vectors;
    int miscompares;

    logic [7:0] exp_frame [0:319];

    vfat_sbit_tx_if #(.NLANES(8)) bus ();

    vfat_sbit_tx #(
        .NLANES   (8),
        .MAX_SKEW (7)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable_i        (enable),
        .mode_i          (mode),
        .pattern_i       (pattern),
        .src             (bus),
        .lane_skew_i     (lane_skew),
        .sof_skew_i      (sof_skew),
        .sbits_o         (sbits),
        .sof_o           (sof),
        .frame_cnt_o     (frame_cnt),
        .underflow_cnt_o (underflow_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic [1:0]  md;
        logic        valid;
        logic [63:0] frame;
        logic        exp_ready;
        logic [7:0]  exp_sbits;
        logic        exp_sof;
    } vec_t;

    vec_t tbl [0:18];

    function automatic vec_t mk(
        input logic v, input logic [63:0] f,
        input logic r, input logic [7:0] s, input logic so
    );
        vec_t x;
        x.en        = 1'b1;
        x.md        = MODE_DATA;
        x.valid     = v;
        x.frame     = f;
        x.exp_ready = r;
        x.exp_sbits = s;
        x.exp_sof   = so;
        return x;
    endfunction

    task automatic chk(
        input string name, input logic [31:0] act, input logic [31:0] exp
    );
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Model: first boundary at edge 1, bit b of frame k of a lane
    // with skew s is visible after edge 2 + 8k + b + s.
    task automatic run_stream(
        input int n, input int sw_edge, input logic [1:0] sw_mode
    );
        for (int t = 1; t <= n; t++) begin
            logic [7:0] es;
            logic       esof;
            int         u;
            @(posedge clock);
            @(negedge clock);
            es = '0;
            for (int i = 0; i < 8; i++) begin
                u = t - 2 - int'(lane_skew[i*3 +: 3]);
                if (u >= 0) es[i] = exp_frame[u/8][u%8];
            end
            u = t - 2 - int'(sof_skew);
            esof = (u >= 0) && (u % 8 == 0);
            chk($sformatf("stream t%0d sbits", t), {24'd0, sbits}, {24'd0, es});
            chk($sformatf("stream t%0d sof", t), {31'd0, sof}, {31'd0, esof});
            if (t == sw_edge) mode = sw_mode;
        end
    endtask

    localparam logic [63:0] F1 = 64'h0000_0000_0000_00A5;
    localparam logic [63:0] F2 = 64'h8100_0000_0000_003C;

    initial begin
        int pulses;
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        enable        = 1'b0;
        mode          = MODE_DATA;
        pattern       = 8'h00;
        lane_skew     = '0;
        sof_skew      = '0;
        bus.frame_i       = '0;
        bus.frame_valid_i = 1'b0;

        tbl[0]  = mk(1, F1, 1, 8'h00, 0);
        tbl[1]  = mk(1, F1, 0, 8'h01, 1);
        tbl[2]  = mk(1, F1, 0, 8'h00, 0);
        tbl[3]  = mk(1, F1, 0, 8'h01, 0);
        tbl[4]  = mk(1, F1, 0, 8'h00, 0);
        tbl[5]  = mk(1, F1, 0, 8'h00, 0);
        tbl[6]  = mk(1, F1, 0, 8'h01, 0);
        tbl[7]  = mk(1, F1, 0, 8'h00, 0);
        tbl[8]  = mk(1, F2, 1, 8'h01, 0);
        tbl[9]  = mk(1, F2, 0, 8'h80, 1);
        tbl[10] = mk(1, F2, 0, 8'h00, 0);
        tbl[11] = mk(1, F2, 0, 8'h01, 0);
        tbl[12] = mk(1, F2, 0, 8'h01, 0);
        tbl[13] = mk(1, F2, 0, 8'h01, 0);
        tbl[14] = mk(1, F2, 0, 8'h01, 0);
        tbl[15] = mk(1, F2, 0, 8'h00, 0);
        tbl[16] = mk(0, F2, 1, 8'h80, 0);
        tbl[17] = mk(0, F2, 0, 8'h00, 1);
        tbl[18] = mk(0, F2, 0, 8'h00, 0);

        do_reset();
        chk("reset sbits", {24'd0, sbits}, 32'd0);
        chk("reset sof", {31'd0, sof}, 32'd0);
        chk("reset frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("reset underflow", {16'd0, underflow_cnt}, 32'd0);

        // DATA table: ready before the edge, serial outputs after it
        for (int i = 0; i < 19; i++) begin
            enable            = tbl[i].en;
            mode              = tbl[i].md;
            bus.frame_valid_i = tbl[i].valid;
            bus.frame_i       = tbl[i].frame;
            #1;
            chk($sformatf("tbl%0d ready", i),
                {31'd0, bus.frame_ready_o}, {31'd0, tbl[i].exp_ready});
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("tbl%0d sbits", i),
                {24'd0, sbits}, {24'd0, tbl[i].exp_sbits});
            chk($sformatf("tbl%0d sof", i),
                {31'd0, sof}, {31'd0, tbl[i].exp_sof});
        end
        chk("tbl frame_cnt", {16'd0, frame_cnt}, 32'd3);
        chk("tbl underflow", {16'd0, underflow_cnt}, 32'd1);

        // DATA with valid low for three boundaries
        do_reset();
        mode              = MODE_DATA;
        bus.frame_valid_i = 1'b0;
        enable            = 1'b1;
        pulses            = 0;
        for (int t = 0; t < 24; t++) begin
            #1;
            if (bus.frame_ready_o) pulses++;
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("underflow t%0d sbits", t), {24'd0, sbits}, 32'd0);
        end
        chk("underflow ready pulses", pulses, 32'd3);
        chk("underflow count", {16'd0, underflow_cnt}, 32'd3);
        chk("underflow frame_cnt", {16'd0, frame_cnt}, 32'd3);

        // FIXED 0xF0, lane3 skew 5
        do_reset();
        mode      = MODE_FIXED;
        pattern   = 8'hF0;
        lane_skew = 24'd5 << 9;
        sof_skew  = 3'd0;
        for (int k = 0; k < 320; k++) exp_frame[k] = 8'hF0;
        enable = 1'b1;
        run_stream(40, 0, MODE_FIXED);

        // FIXED 0xA5, lane i skew i, SOF skew 2
        do_reset();
        pattern = 8'hA5;
        for (int i = 0; i < 8; i++) lane_skew[i*3 +: 3] = 3'(i);
        sof_skew = 3'd2;
        for (int k = 0; k < 320; k++) exp_frame[k] = 8'hA5;
        enable = 1'b1;
        run_stream(40, 0, MODE_FIXED);

        // COUNTER, 300 frames
        do_reset();
        mode      = MODE_COUNTER;
        lane_skew = '0;
        sof_skew  = '0;
        for (int k = 0; k < 320; k++) exp_frame[k] = 8'(k);
        enable = 1'b1;
        run_stream(2400, 0, MODE_COUNTER);
        chk("counter frame_cnt", {16'd0, frame_cnt}, 32'd300);
        enable = 1'b0;

        // FIXED -> IDLE switch at bit_cnt 3
        do_reset();
        mode    = MODE_FIXED;
        pattern = 8'hFF;
        for (int k = 0; k < 320; k++) exp_frame[k] = (k == 0) ? 8'hFF : 8'h00;
        enable = 1'b1;
        run_stream(20, 4, MODE_IDLE);

        // Reset mid-frame at bit_cnt 4
        do_reset();
        mode = MODE_FIXED;
        for (int k = 0; k < 320; k++) exp_frame[k] = 8'hFF;
        enable = 1'b1;
        run_stream(5, 0, MODE_FIXED);
        reset = 1'b1;
        #1;
        chk("midrst sbits", {24'd0, sbits}, 32'd0);
        chk("midrst sof", {31'd0, sof}, 32'd0);
        chk("midrst frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("midrst underflow", {16'd0, underflow_cnt}, 32'd0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("release e1 sof", {31'd0, sof}, 32'd0);
        chk("release e1 sbits", {24'd0, sbits}, 32'd0);
        chk("release e1 frame_cnt", {16'd0, frame_cnt}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        chk("release e2 sof", {31'd0, sof}, 32'd1);
        chk("release e2 sbits", {24'd0, sbits}, 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
